// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared FSM state type and Game-of-Life rule constants
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } life_state_e;

  localparam int unsigned BIRTH   = 3;
  localparam int unsigned SURV_LO = 2;
  localparam int unsigned SURV_HI = 3;

endpackage

// File: rtl/life_next_state.sv
// rtl/life_next_state.sv - one cell's next-generation rule from its 8 neighbours
module life_next_state
  import life_pkg::*;
(
  input  logic [7:0] nbr_i,
  input  logic       self_i,
  output logic       next_o
);

  logic [3:0] cnt;

  // population count of the 8 neighbours, 0..8
  always_comb begin
    cnt = 4'd0;
    for (int k = 0; k < 8; k++) begin
      cnt = cnt + {3'b000, nbr_i[k]};
    end
  end

  // survival for live cells, birth for dead cells
  always_comb begin
    if (self_i) begin
      next_o = (cnt >= 4'(SURV_LO)) && (cnt <= 4'(SURV_HI));
    end else begin
      next_o = (cnt == 4'(BIRTH));
    end
  end

endmodule

// File: rtl/life_array_nxn.sv
// rtl/life_array_nxn.sv - ROWS x COLS Game-of-Life array with load/readback, step/run and auto-halt
module life_array_nxn
  import life_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int WRAP  = 0,
  parameter int GEN_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COLS-1:0]         vali,
  input  logic [$clog2(ROWS)-1:0] vali_selector,
  input  logic                    write_enb,
  input  logic [$clog2(ROWS)-1:0] valo_selector,
  output logic [COLS-1:0]         valo,
  output logic [COLS-1:0]         valo_prev,
  input  logic                    step,
  input  logic                    run,
  input  logic                    clr_gen,
  input  logic [COLS-1:0]         ni,
  input  logic [COLS-1:0]         si,
  input  logic [ROWS-1:0]         wi,
  input  logic [ROWS-1:0]         ei,
  input  logic                    nw,
  input  logic                    ne,
  input  logic                    se,
  input  logic                    sw,
  output logic [COLS-1:0]         no,
  output logic [COLS-1:0]         so,
  output logic [ROWS-1:0]         wo,
  output logic [ROWS-1:0]         eo,
  output logic [GEN_W-1:0]        gen_count,
  output logic                    stable,
  output logic                    alive
);

  logic [ROWS-1:0][COLS-1:0] cur_q, cur_d, prev_q, prev_d, nxt;
  logic [ROWS+1:0][COLS+1:0] frame;
  logic [GEN_W-1:0]          gen_q, gen_d;
  logic                      stable_q, stable_d;
  logic                      step_pend_q, step_pend_d;
  logic                      do_upd, same;
  life_state_e               state_q, state_d;

  // edge inputs are simply ignored in toroidal mode
  logic unused_edges;
  assign unused_edges = ^{ni, si, wi, ei, nw, ne, se, sw};

  // padded frame: interior is cur, the one-cell border is either the edge inputs or the wrapped array
  always_comb begin
    frame = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        frame[r+1][c+1] = cur_q[r][c];
      end
    end
    if (WRAP != 0) begin
      for (int c = 0; c < COLS; c++) begin
        frame[0][c+1]      = cur_q[ROWS-1][c];
        frame[ROWS+1][c+1] = cur_q[0][c];
      end
      for (int r = 0; r < ROWS; r++) begin
        frame[r+1][0]      = cur_q[r][COLS-1];
        frame[r+1][COLS+1] = cur_q[r][0];
      end
      frame[0][0]           = cur_q[ROWS-1][COLS-1];
      frame[0][COLS+1]      = cur_q[ROWS-1][0];
      frame[ROWS+1][0]      = cur_q[0][COLS-1];
      frame[ROWS+1][COLS+1] = cur_q[0][0];
    end else begin
      for (int c = 0; c < COLS; c++) begin
        frame[0][c+1]      = ni[c];
        frame[ROWS+1][c+1] = si[c];
      end
      for (int r = 0; r < ROWS; r++) begin
        frame[r+1][0]      = wi[r];
        frame[r+1][COLS+1] = ei[r];
      end
      frame[0][0]           = nw;
      frame[0][COLS+1]      = ne;
      frame[ROWS+1][0]      = sw;
      frame[ROWS+1][COLS+1] = se;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      life_next_state u_cell (
        .nbr_i  ({frame[r][c],   frame[r][c+1],   frame[r][c+2],
                  frame[r+1][c],                  frame[r+1][c+2],
                  frame[r+2][c], frame[r+2][c+1], frame[r+2][c+2]}),
        .self_i (cur_q[r][c]),
        .next_o (nxt[r][c])
      );
    end
  end

  assign same = (nxt == cur_q);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a write in RUN suppresses the update, so it cannot trigger the halt
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (run) state_d = RUN;
      RUN: begin
        if (!run)                       state_d = IDLE;
        else if (!write_enb && same)    state_d = HALT;
      end
      HALT: if (!run || write_enb) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: when to update, and the pending step that a write pushed back by one cycle
  always_comb begin
    do_upd      = 1'b0;
    step_pend_d = step_pend_q;
    unique case (state_q)
      IDLE: begin
        if (write_enb) begin
          if (step) step_pend_d = 1'b1;
        end else if (step || step_pend_q) begin
          do_upd      = 1'b1;
          step_pend_d = 1'b0;
        end
      end
      RUN:     do_upd = run && !write_enb;
      default: do_upd = 1'b0;
    endcase
  end

  // datapath next values: write beats update, clr_gen beats increment
  always_comb begin
    cur_d    = cur_q;
    prev_d   = prev_q;
    gen_d    = gen_q;
    stable_d = stable_q;
    if (write_enb) begin
      if (int'(vali_selector) < ROWS) cur_d[vali_selector] = vali;
      stable_d = 1'b0;
    end else if (do_upd) begin
      prev_d   = cur_q;
      cur_d    = nxt;
      gen_d    = gen_q + GEN_W'(1);
      stable_d = same;
    end
    if (clr_gen) gen_d = '0;
  end

  // datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_q       <= '0;
      prev_q      <= '0;
      gen_q       <= '0;
      stable_q    <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      gen_q       <= gen_d;
      stable_q    <= stable_d;
      step_pend_q <= step_pend_d;
    end
  end

  // row readback muxes
  always_comb begin
    valo      = '0;
    valo_prev = '0;
    if (int'(valo_selector) < ROWS) begin
      valo      = cur_q[valo_selector];
      valo_prev = prev_q[valo_selector];
    end
  end

  // edge columns straight from the cur registers
  always_comb begin
    wo = '0;
    eo = '0;
    for (int r = 0; r < ROWS; r++) begin
      wo[r] = cur_q[r][0];
      eo[r] = cur_q[r][COLS-1];
    end
  end

  assign no        = cur_q[0];
  assign so        = cur_q[ROWS-1];
  assign gen_count = gen_q;
  assign stable    = stable_q;
  assign alive     = |cur_q;

endmodule
